// File: rtl/img2col_window_sequencer_if.sv
// Control/status bundle between the img2col datapath controller and the window sequencer.
// The sequencer side uses the slave modport; the controller (or bench) uses master.
interface img2col_window_sequencer_if #(
  parameter int CNT_W = 9,
  parameter int WIN_W = 8
);
  logic             start;
  logic             map_finish;
  logic             stall;
  logic [CNT_W-1:0] cfg_preload;
  logic [CNT_W-1:0] cfg_gap;
  logic [CNT_W-1:0] cfg_active;
  logic [WIN_W-1:0] cfg_windows;
  logic             flag;
  logic [CNT_W-1:0] beat_idx;
  logic [WIN_W-1:0] win_idx;
  logic             win_last;
  logic             busy;
  logic             done;

  modport master (
    output start, map_finish, stall, cfg_preload, cfg_gap, cfg_active, cfg_windows,
    input  flag, beat_idx, win_idx, win_last, busy, done
  );

  modport slave (
    input  start, map_finish, stall, cfg_preload, cfg_gap, cfg_active, cfg_windows,
    output flag, beat_idx, win_idx, win_last, busy, done
  );
endinterface

// File: rtl/img2col_window_sequencer.sv
// Preload / gap / active window sequencer; state registered, flag = registered ACTIVE gated by stall.
// Stall freezes state and counters; map_finish ends the map after the current window.
module img2col_window_sequencer #(
  parameter int CNT_W = 9,
  parameter int WIN_W = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  img2col_window_sequencer_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_GAP,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIN_W-1:0] r_win;
  logic             r_fin;
  logic [CNT_W-1:0] r_preload;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_active;
  logic [WIN_W-1:0] r_windows;

  state_t           w_state_nxt;
  state_t           w_after_gap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIN_W-1:0] w_win_nxt;
  logic             w_fin_nxt;
  logic [CNT_W-1:0] w_len;
  logic             w_phase_end;
  logic             w_last_win;
  logic             w_take_start;

  assign w_take_start = (r_state == S_IDLE) && io.start;
  assign w_after_gap  = (r_gap != '0) ? S_GAP : S_ACTIVE;
  assign w_last_win   = (r_win == r_windows - WIN_W'(1));

  always_comb begin
    w_len = '0;
    case (r_state)
      S_PRELOAD: w_len = r_preload;
      S_GAP:     w_len = r_gap;
      S_ACTIVE:  w_len = r_active;
      default:   w_len = '0;
    endcase
  end

  // Only consulted in phases whose latched length is known to be non-zero.
  assign w_phase_end = (r_cnt == w_len - CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_win_nxt   = r_win;
    w_fin_nxt   = r_fin;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_win_nxt = '0;
        w_fin_nxt = 1'b0;
        if (io.start) begin
          if (io.cfg_active == '0 || io.cfg_windows == '0) w_state_nxt = S_DONE;
          else if (io.cfg_preload != '0)                    w_state_nxt = S_PRELOAD;
          else if (io.cfg_gap != '0)                        w_state_nxt = S_GAP;
          else                                              w_state_nxt = S_ACTIVE;
        end
      end
      S_PRELOAD, S_GAP: begin
        // A finish request between windows ends the map at once, even while stalled.
        if (io.map_finish || r_fin) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
          w_fin_nxt   = 1'b1;
        end else if (!io.stall) begin
          if (w_phase_end) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_state == S_PRELOAD) ? w_after_gap : S_ACTIVE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_ACTIVE: begin
        w_fin_nxt = r_fin | io.map_finish;
        if (!io.stall) begin
          if (w_phase_end) begin
            w_cnt_nxt = '0;
            if (w_last_win || r_fin || io.map_finish) begin
              w_state_nxt = S_DONE;
            end else begin
              w_win_nxt   = r_win + WIN_W'(1);
              w_state_nxt = w_after_gap;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_win_nxt   = '0;
        w_fin_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_win_nxt   = '0;
        w_fin_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_win   <= '0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_win   <= w_win_nxt;
      r_fin   <= w_fin_nxt;
    end
  end

  // Configuration is captured once per map so mid-run changes cannot disturb it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_preload <= '0;
      r_gap     <= '0;
      r_active  <= '0;
      r_windows <= '0;
    end else if (w_take_start) begin
      r_preload <= io.cfg_preload;
      r_gap     <= io.cfg_gap;
      r_active  <= io.cfg_active;
      r_windows <= io.cfg_windows;
    end
  end

  assign io.flag     = (r_state == S_ACTIVE) && !io.stall;
  assign io.beat_idx = (r_state == S_ACTIVE) ? r_cnt : '0;
  assign io.win_idx  = r_win;
  assign io.win_last = (r_state == S_ACTIVE) && w_last_win;
  assign io.busy     = (r_state != S_IDLE);
  assign io.done     = (r_state == S_DONE);

endmodule
